// File: rtl/cyber_melody_pkg.sv
// Shared definitions for the melody sequencer: score entry layout, rest code and FSM states.
package cyber_melody_pkg;

    localparam logic [3:0] NOTE_REST = 4'd15;

    localparam int NOTE_MSB = 15;
    localparam int NOTE_LSB = 12;
    localparam int OCT_MSB  = 11;
    localparam int OCT_LSB  = 8;
    localparam int DUR_MSB  = 7;
    localparam int DUR_LSB  = 0;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        PLAY,
        DONE
    } seq_state_e;

    function automatic logic [3:0] entry_note(input logic [15:0] entry);
        return entry[NOTE_MSB:NOTE_LSB];
    endfunction

    function automatic logic [3:0] entry_octave(input logic [15:0] entry);
        return entry[OCT_MSB:OCT_LSB];
    endfunction

    function automatic logic [7:0] entry_duration(input logic [15:0] entry);
        return entry[DUR_MSB:DUR_LSB];
    endfunction

endpackage

// File: rtl/tempo_tick.sv
// Tempo divider: one-cycle tick every TICK_DIV enabled clocks; clr restarts the count.
module tempo_tick #(
    parameter int TICK_DIV = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = en && !clr && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/melody_sequencer.sv
// Plays a score from a synchronous ROM, one entry per note, durations counted in tempo ticks.
// Define SEQ_LOOP_EN to restart the score at address 0 on the end marker instead of stopping.
module melody_sequencer
    import cyber_melody_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int TICK_DIV = 250000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [3:0]        note,
    output logic [3:0]        octave,
    output logic              mute,
    output logic              playing,
    output logic              done
);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        note_q, note_d;
    logic [3:0]        octave_q, octave_d;
    logic              mute_q, mute_d;
    logic [7:0]        dur_q, dur_d;

    logic tick_clr;
    logic tick_en;
    logic tick;

    assign tick_en = (state_q == FETCH) || (state_q == LOAD) || (state_q == PLAY);

    tempo_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_tempo_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (tick_clr),
        .en   (tick_en),
        .tick (tick)
    );

    // Pitch registers only change in LOAD, so the previous note keeps sounding across FETCH/LOAD.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        note_d   = note_q;
        octave_d = octave_q;
        mute_d   = mute_q;
        dur_d    = dur_q;
        tick_clr = 1'b0;

        if (stop) begin
            state_d = IDLE;
            mute_d  = 1'b1;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        addr_d   = '0;
                        tick_clr = 1'b1;
                        state_d  = FETCH;
                    end
                end
                FETCH: state_d = LOAD;
                LOAD: begin
                    if (entry_duration(rom_data) != 8'd0) begin
                        note_d   = entry_note(rom_data);
                        octave_d = entry_octave(rom_data);
                        mute_d   = (entry_note(rom_data) == NOTE_REST);
                        dur_d    = entry_duration(rom_data);
                        state_d  = PLAY;
                    end else begin
`ifdef SEQ_LOOP_EN
                        addr_d  = '0;
                        state_d = FETCH;
`else
                        mute_d  = 1'b1;
                        state_d = DONE;
`endif
                    end
                end
                PLAY: begin
                    if (tick) begin
                        dur_d = dur_q - 8'd1;
                        if (dur_q == 8'd1) begin
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = FETCH;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            note_q   <= 4'd0;
            octave_q <= 4'd0;
            mute_q   <= 1'b1;
            dur_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            note_q   <= note_d;
            octave_q <= octave_d;
            mute_q   <= mute_d;
            dur_q    <= dur_d;
        end
    end

    assign rom_addr = addr_q;
    assign note     = note_q;
    assign octave   = octave_q;
    assign mute     = mute_q;
    assign playing  = tick_en;
    assign done     = (state_q == DONE);

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with TICK_DIV=4 and a four-entry score.
module tb_melody_sequencer;

    localparam int ADDR_W   = 8;
    localparam int TICK_DIV = 4;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              stop  = 1'b0;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic [3:0]        note;
    logic [3:0]        octave;
    logic              mute;
    logic              playing;
    logic              done;

    logic [15:0] rom [0:255];

    int vectors     = 0;
    int miscompares = 0;
    int edgeNo      = 0;

    melody_sequencer #(
        .ADDR_W  (ADDR_W),
        .TICK_DIV(TICK_DIV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .note    (note),
        .octave  (octave),
        .mute    (mute),
        .playing (playing),
        .done    (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic step();
        @(posedge clk);
        #1;
        edgeNo++;
    endtask

    task automatic stepTo(input int target);
        while (edgeNo < target) step();
    endtask

    task automatic applyStimulus();
        start = 1'b1;
        step();
        start  = 1'b0;
        edgeNo = 0;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input int expAddr, input int expNote, input int expOct,
                            input bit expMute, input bit expPlaying, input bit expDone);
        checkOutput({tag, ".rom_addr"}, 16'(rom_addr), 16'(expAddr));
        checkOutput({tag, ".note"},     16'(note),     16'(expNote));
        checkOutput({tag, ".octave"},   16'(octave),   16'(expOct));
        checkOutput({tag, ".mute"},     16'(mute),     16'(expMute));
        checkOutput({tag, ".playing"},  16'(playing),  16'(expPlaying));
        checkOutput({tag, ".done"},     16'(done),     16'(expDone));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[0] = 16'h9702;
        rom[1] = 16'hF401;
        rom[2] = 16'h0503;
        rom[3] = 16'h0000;

        #1 rst_n = 1'b0;
        step();
        step();
        checkAll("reset", 0, 0, 0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        checkAll("idle", 0, 0, 0, 1'b1, 1'b0, 1'b0);

        applyStimulus();
        checkAll("e0.fetch", 0, 0, 0, 1'b1, 1'b1, 1'b0);
        stepTo(1);
        checkAll("e1.load", 0, 0, 0, 1'b1, 1'b1, 1'b0);
        stepTo(2);
        checkAll("e2.entry0", 0, 9, 7, 1'b0, 1'b1, 1'b0);
        stepTo(7);
        checkAll("e7.entry0", 0, 9, 7, 1'b0, 1'b1, 1'b0);
        stepTo(8);
        checkAll("e8.fetch1", 1, 9, 7, 1'b0, 1'b1, 1'b0);
        stepTo(9);
        checkAll("e9.load1", 1, 9, 7, 1'b0, 1'b1, 1'b0);
        stepTo(10);
        checkAll("e10.rest", 1, 15, 4, 1'b1, 1'b1, 1'b0);
        stepTo(12);
        checkAll("e12.fetch2", 2, 15, 4, 1'b1, 1'b1, 1'b0);
        stepTo(14);
        checkAll("e14.entry2", 2, 0, 5, 1'b0, 1'b1, 1'b0);
        stepTo(23);
        checkAll("e23.entry2", 2, 0, 5, 1'b0, 1'b1, 1'b0);
        stepTo(24);
        checkAll("e24.fetch3", 3, 0, 5, 1'b0, 1'b1, 1'b0);
        stepTo(26);
`ifdef SEQ_LOOP_EN
        checkAll("e26.loop", 0, 0, 5, 1'b0, 1'b1, 1'b0);
        stepTo(28);
        checkAll("e28.replay", 0, 9, 7, 1'b0, 1'b1, 1'b0);
        stepTo(29);
`else
        checkAll("e26.end", 3, 0, 5, 1'b1, 1'b0, 1'b1);
        stepTo(30);
        checkAll("e30.done", 3, 0, 5, 1'b1, 1'b0, 1'b1);
        applyStimulus();
        checkAll("restart", 0, 0, 5, 1'b1, 1'b1, 1'b0);
        stepTo(2);
        checkAll("restart.e2", 0, 9, 7, 1'b0, 1'b1, 1'b0);
        stepTo(3);
`endif

        // Reset asserted between clock edges while a note is playing.
        #2 rst_n = 1'b0;
        #1;
        checkAll("asyncReset", 0, 0, 0, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        step();
        step();
        step();
        checkAll("noResume", 0, 0, 0, 1'b1, 1'b0, 1'b0);

        applyStimulus();
        stepTo(6);
        start = 1'b1;
        stepTo(7);
        start = 1'b0;
        stepTo(8);
        checkAll("startIgnored", 1, 9, 7, 1'b0, 1'b1, 1'b0);
        stepTo(16);
        checkOutput("preStop.note", 16'(note), 16'd0);
        stop = 1'b1;
        stepTo(17);
        stop = 1'b0;
        checkOutput("stop.playing", 16'(playing), 16'd0);
        checkOutput("stop.mute",    16'(mute),    16'd1);
        checkOutput("stop.done",    16'(done),    16'd0);
        stepTo(20);
        checkOutput("stopHold.playing", 16'(playing), 16'd0);
        checkOutput("stopHold.mute",    16'(mute),    16'd1);

        stop  = 1'b1;
        start = 1'b1;
        step();
        stop  = 1'b0;
        start = 1'b0;
        checkOutput("stopStart.playing", 16'(playing), 16'd0);
        checkOutput("stopStart.mute",    16'(mute),    16'd1);
        checkOutput("stopStart.done",    16'(done),    16'd0);
        step();
        checkOutput("stopStart.idle", 16'(playing), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/melody_sequencer.md
MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: score ROM address width.
REQ-002 SHALL have parameter TICK_DIV, default 250000: clk cycles per tempo tick (≥2).
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle request to begin playback at address 0.
REQ-006 SHALL have port stop  input  1  single-cycle request to abort playback.
REQ-007 SHALL have port rom_addr  output  ADDR_W  registered score ROM address.
REQ-008 SHALL have port rom_data  input  16  score entry: [15:12] note, [11:8] octave, [7:0] duration in ticks.
REQ-009 SHALL have ports note  output  4 and octave  output  4: registered pitch to pitch_generator.
REQ-010 SHALL have port mute  output  1  high = pitch output silenced.
REQ-011 SHALL have ports playing  output  1 and done  output  1: status.

Function
REQ-012 SHALL treat rom_data as valid exactly one cycle after rom_addr changes (synchronous ROM).
REQ-013 SHALL implement FSM states IDLE, FETCH, LOAD, PLAY, DONE.
REQ-014 IDLE or DONE + start: rom_addr<=0, tick divider cleared, done<=0, go FETCH; start in FETCH/LOAD/PLAY SHALL be ignored.
REQ-015 FETCH SHALL last one cycle then go LOAD.
REQ-016 LOAD with duration≠0: note/octave<=fields, mute<=(note==15), duration counter<=duration, go PLAY.
REQ-017 LOAD with duration==0 (end marker): mute<=1, done<=1, go DONE; note/octave hold.
REQ-018 PLAY: counter SHALL decrement once per tick; on the tick where counter==1, rom_addr<=rom_addr+1 and go FETCH.
REQ-019 note/octave/mute SHALL hold previous values through FETCH and LOAD until updated (no gap glitch).
REQ-020 rom_addr increment SHALL wrap modulo 2^ADDR_W without stopping.
REQ-021 tick SHALL be a one-cycle pulse every TICK_DIV cycles, counting only in FETCH/LOAD/PLAY.
REQ-022 stop in any state SHALL go IDLE next edge with mute<=1, playing<=0, done<=0; stop+start same cycle: stop wins.
REQ-023 playing SHALL be 1 exactly in FETCH, LOAD, PLAY.
REQ-024 note values 12–14 SHALL be passed through unchanged (pitch_generator defines result); 15 = rest.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, rom_addr=0, note=0, octave=0, mute=1, playing=0, done=0, counters=0.
REQ-026 Deassertion mid-score SHALL not resume; start is required.

Configuration
REQ-027 With SEQ_LOOP_EN defined, an end marker SHALL set rom_addr<=0 and go FETCH (done stays 0, mute holds previous value until next LOAD).
REQ-028 Without SEQ_LOOP_EN, end marker behaviour SHALL be REQ-017.

Structure
REQ-029 Package cyber_melody_pkg SHALL hold NOTE_REST=15, entry field bit positions, and the FSM state enum.
REQ-030 Tick generation SHALL be a sub-module tempo_tick (clk, rst_n, clr, en, tick), parameter TICK_DIV.

Verification (TICK_DIV=4, ROM: 0=0x9_7_02, 1=0xF_4_01, 2=0x0_5_03, 3=0x0000)
REQ-031 start at cycle 0 -> rom_addr 0, LOAD at cycle 2 gives note=9 octave=7 mute=0; held 8 cycles (2 ticks); rom_addr=1.
REQ-032 entry 1 -> mute=1 for 1 tick, note=15; entry 2 -> note=0 octave=5 mute=0 for 3 ticks.
REQ-033 end marker -> done=1, playing=0, mute=1; start again restarts at addr 0 with done cleared.
REQ-034 stop asserted mid entry 2 -> next cycle IDLE, mute=1; stop+start same cycle -> IDLE.
REQ-035 rst_n pulsed low mid-PLAY -> all outputs at reset values same cycle asynchronously.
REQ-036 SEQ_LOOP_EN defined -> after entry 2 expires, rom_addr=0 and note=9 replays; done never asserts.
